// File: rtl/sys_reset_ce.sv
// Power-up reset sequencer: qualifies PLL lock, holds sys_rst_n low for a fixed
// window, then generates free-running CPU and pixel clock-enable pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | synchronized lock low, nothing running
// STABLE    | lock high, counting LOCK_CYCLES consecutive locked cycles
// HOLD      | lock qualified, sys_rst_n held low for HOLD_CYCLES
// RUN       | sys_rst_n/ready high, clock enables active
module sys_reset_ce #(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 64,
    parameter int CPU_DIV     = 15,
    parameter int PIX_DIV     = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic pll_lock,
    input  logic soft_reset,
    output logic sys_rst_n,
    output logic ready,
    output logic cpu_ce,
    output logic pix_ce
);

    localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int CPU_W   = $clog2(CPU_DIV);
    localparam int PIX_W   = $clog2(PIX_DIV);

    localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CPU_W-1:0] CPU_LAST  = CPU_W'(CPU_DIV - 1);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic             sync1_q, lock_s_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CPU_W-1:0] cpu_cnt_q, cpu_cnt_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             pix_ce_q, pix_ce_d;
    logic             run_d, run_stay;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        run_d       = (state_d == RUN);
        run_stay    = (state_q == RUN) && run_d;
        sys_rst_n_d = run_d;
        ready_d     = run_d;

        cpu_cnt_d = '0;
        pix_cnt_d = '0;
        if (run_stay) begin
            cpu_cnt_d = (cpu_cnt_q == CPU_LAST) ? '0 : cpu_cnt_q + CPU_W'(1);
            pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
        end
        cpu_ce_d = run_d && (cpu_cnt_d == CPU_LAST);
        pix_ce_d = run_d && (pix_cnt_d == PIX_LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            cpu_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            cpu_ce_q    <= 1'b0;
            pix_ce_q    <= 1'b0;
        end else begin
            sync1_q     <= pll_lock;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_cnt_q   <= cpu_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            cpu_ce_q    <= cpu_ce_d;
            pix_ce_q    <= pix_ce_d;
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign cpu_ce    = cpu_ce_q;
    assign pix_ce    = pix_ce_q;

endmodule

// File: tb/tb_sys_reset_ce.sv
// Directed bench for sys_reset_ce: expected reset edges and clock-enable pulse
// cycles are queued ahead of time and matched by a negedge monitor.
module tb_sys_reset_ce;

    localparam int LOCK = 1024;
    localparam int HOLD = 64;
    localparam int CDIV = 15;
    localparam int PDIV = 10;
    // release -> first RUN sample: 2 sync edges, 1 edge to leave WAIT_LOCK, then STABLE and HOLD
    localparam int SEQ  = 2 + 1 + LOCK + HOLD;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pll_lock = 1'b1;
    logic soft_reset = 1'b0;
    logic sys_rst_n, ready, cpu_ce, pix_ce;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } ev_t;

    ev_t ev_q[$];
    int  cpu_q[$];
    int  pix_q[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int cpu_seen = 0;
    int pix_seen = 0;
    bit mon_en = 1'b0;
    logic [1:0] prev_ev = 2'b00;

    int t0, r1, d, l, g, r2, q, r3, q2, r4, a, t1, h, t2, r5, c0, p0;

    sys_reset_ce #(
        .LOCK_CYCLES(LOCK),
        .HOLD_CYCLES(HOLD),
        .CPU_DIV(CDIV),
        .PIX_DIV(PDIV)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pll_lock(pll_lock),
        .soft_reset(soft_reset),
        .sys_rst_n(sys_rst_n),
        .ready(ready),
        .cpu_ce(cpu_ce),
        .pix_ce(pix_ce)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        ev_q.push_back(e);
    endtask

    // RUN sample r is RUN cycle 1; pulses land on every DIV-th RUN cycle up to `last`.
    task automatic push_run(input int r, input int last);
        for (int k = 1; r + k - 1 <= last; k++) begin
            if (k % CDIV == 0) cpu_q.push_back(r + k - 1);
            if (k % PDIV == 0) pix_q.push_back(r + k - 1);
        end
    endtask

    // Returns 3 time units after the posedge that makes cyc == c.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
        check({tag, "_ready"},     32'(ready),     32'd0);
        check({tag, "_cpu_ce"},    32'(cpu_ce),    32'd0);
        check({tag, "_pix_ce"},    32'(pix_ce),    32'd0);
    endtask

    always @(negedge clk) begin
        ev_t        e;
        logic [1:0] cur;
        int         exp_c;
        if (mon_en) begin
            cur = {sys_rst_n, ready};
            if (cur !== prev_ev) begin
                if (ev_q.size() > 0) begin
                    e = ev_q.pop_front();
                    check("rst_edge_cyc", cyc, e.cyc);
                    check("rst_edge_val", 32'(cur), 32'(e.val));
                end else begin
                    check("rst_edge_unexpected", cyc, -1);
                end
                prev_ev = cur;
            end
            if (cpu_ce !== 1'b0) begin
                cpu_seen++;
                exp_c = (cpu_q.size() > 0) ? cpu_q.pop_front() : -1;
                check("cpu_ce_cyc", cyc, exp_c);
            end
            if (pix_ce !== 1'b0) begin
                pix_seen++;
                exp_c = (pix_q.size() > 0) ? pix_q.pop_front() : -1;
                check("pix_ce_cyc", cyc, exp_c);
            end
        end
    end

    initial begin
        // Power-up with lock already high.
        wait_until(3);
        check_all_low("reset");
        t0 = cyc;
        r1 = t0 + SEQ;
        d  = r1 + 310;
        push_ev(r1, 2'b11);
        push_ev(d + 3, 2'b00);
        push_run(r1, d + 2);
        mon_en = 1'b1;
        resetn = 1'b1;

        wait_until(r1);
        c0 = cpu_seen;
        p0 = pix_seen;
        wait_until(r1 + 300);
        check("cpu_ce_count_300", cpu_seen - c0, 300 / CDIV);
        check("pix_ce_count_300", pix_seen - p0, 300 / PDIV);

        // Lock loss in RUN: outputs fall 3 edges later.
        wait_until(d);
        pll_lock = 1'b0;

        // Lock returns, then a one-cycle glitch 500 cycles into STABLE.
        l  = d + 23;
        g  = l + 503;
        r2 = g + 1 + SEQ;
        q  = r2 + 100;
        r3 = q + 1 + 30 + HOLD;
        push_ev(r2, 2'b11);
        push_ev(q + 1, 2'b00);
        push_ev(r3, 2'b11);
        push_run(r2, q);
        wait_until(l);
        pll_lock = 1'b1;
        wait_until(g);
        pll_lock = 1'b0;
        wait_until(g + 1);
        pll_lock = 1'b1;

        // Soft reset in RUN, then again 30 cycles into HOLD to restart the count.
        wait_until(q);
        soft_reset = 1'b1;
        wait_until(q + 1);
        soft_reset = 1'b0;
        wait_until(q + 30);
        soft_reset = 1'b1;
        wait_until(q + 31);
        soft_reset = 1'b0;

        // Plain soft reset: 64 low cycles, dividers restart, then async reset mid-RUN.
        q2 = r3 + 40;
        r4 = q2 + 1 + HOLD;
        a  = r4 + 45;
        push_run(r3, q2);
        push_ev(q2 + 1, 2'b00);
        push_ev(r4, 2'b11);
        push_run(r4, a - 1);
        push_ev(a, 2'b00);
        wait_until(q2);
        soft_reset = 1'b1;
        wait_until(q2 + 1);
        soft_reset = 1'b0;
        wait_until(a);
        resetn = 1'b0;
        #1;
        check_all_low("async_rst_run");

        // Reset asserted mid-HOLD together with soft_reset; full sequence must rerun.
        wait_until(a + 3);
        t1 = cyc;
        resetn = 1'b1;
        h = t1 + 1050;
        wait_until(h);
        resetn = 1'b0;
        soft_reset = 1'b1;
        #1;
        check_all_low("async_rst_hold");
        wait_until(h + 3);
        t2 = cyc;
        r5 = t2 + SEQ;
        push_ev(r5, 2'b11);
        push_run(r5, r5 + 60);
        resetn = 1'b1;
        wait_until(t2 + 10);
        soft_reset = 1'b0;

        wait_until(r5 + 61);
        check("ev_q_drained",  ev_q.size(),  0);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("pix_q_drained", pix_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
